// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo up/down counter with prescaler, saturate/wrap and rollover pulse
//
// Purpose: counts 0..MODULUS-1 in either direction, advancing one step every
//          PRESCALE enabled clock edges. At a boundary it either wraps
//          (SATURATE=0) or holds (SATURATE=1); either way a one-cycle
//          rollover pulse follows the boundary step.
//
// Ports:
//   clock      in   rising-edge clock for all state
//   reset_n    in   asynchronous active-low reset
//   clear      in   synchronous clear of count and prescaler
//   load       in   synchronous load of load_value (clamped to MODULUS-1)
//   load_value in   N-bit value applied on load
//   enable     in   qualifies prescaler advance and count steps
//   up         in   direction: 1 = increment, 0 = decrement
//   cnt        out  registered count value
//   tc         out  combinational terminal count for the current direction
//   rollover   out  registered one-cycle pulse after a boundary step

module mod_counter #(
  parameter int N        = 8,
  parameter int MODULUS  = 2**N,
  parameter bit SATURATE = 1'b0,
  parameter int PRESCALE = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic         enable,
  input  logic         up,
  output logic [N-1:0] cnt,
  output logic         tc,
  output logic         rollover
);

  // 64-bit comparison so that N=32 does not overflow the bound.
  if ((MODULUS < 2) || (64'(MODULUS) > (64'd1 << N)) || (PRESCALE < 1)) begin : g_bad_params
    $fatal(1, "mod_counter: illegal parameters N=%0d MODULUS=%0d PRESCALE=%0d",
           N, MODULUS, PRESCALE);
  end

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [N-1:0]  CNT_MAX  = N'(MODULUS - 1);
  localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] psc;
  logic [PW-1:0] psc_next;
  logic [N-1:0]  cnt_next;
  logic          roll_next;
  logic          step;

  always_comb begin
    tc = up ? (cnt == CNT_MAX) : (cnt == '0);
  end

  // With PRESCALE=1 the prescaler is pinned at 0, so every enabled edge steps.
  assign step = enable && (psc == PSC_LAST);

  always_comb begin
    cnt_next  = cnt;
    psc_next  = psc;
    roll_next = 1'b0;
    if (clear) begin
      cnt_next = '0;
      psc_next = '0;
    end else if (load) begin
      cnt_next = (load_value > CNT_MAX) ? CNT_MAX : load_value;
      psc_next = '0;
    end else if (enable) begin
      if (step) begin
        psc_next = '0;
        if (tc) begin
          // Boundary step: pulse in both modes, only wrap mode moves cnt.
          roll_next = 1'b1;
          if (!SATURATE) begin
            cnt_next = up ? '0 : CNT_MAX;
          end
        end else begin
          cnt_next = up ? (cnt + N'(1)) : (cnt - N'(1));
        end
      end else begin
        psc_next = psc + PW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      psc      <= '0;
      rollover <= 1'b0;
    end else begin
      cnt      <= cnt_next;
      psc      <= psc_next;
      rollover <= roll_next;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - scoreboard bench for mod_counter over four parameterisations

module tb_mod_counter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       clear;
  logic       load;
  logic [3:0] load_value;
  logic       enable;
  logic       up;
  logic [1:0] cnt0;
  logic [3:0] cnt1, cnt2, cnt3;
  logic [3:0] tc;
  logic [3:0] roll;

  always #5 clock = ~clock;

  // d0: N=2 defaults; d1: N=4 mod 10 wrap; d2: N=4 mod 10 saturate; d3: N=4 mod 10 prescale 3
  mod_counter #(.N(2)) d0 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load),
    .load_value(load_value[1:0]), .enable(enable), .up(up),
    .cnt(cnt0), .tc(tc[0]), .rollover(roll[0]));
  mod_counter #(.N(4), .MODULUS(10)) d1 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load),
    .load_value(load_value), .enable(enable), .up(up),
    .cnt(cnt1), .tc(tc[1]), .rollover(roll[1]));
  mod_counter #(.N(4), .MODULUS(10), .SATURATE(1'b1)) d2 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load),
    .load_value(load_value), .enable(enable), .up(up),
    .cnt(cnt2), .tc(tc[2]), .rollover(roll[2]));
  mod_counter #(.N(4), .MODULUS(10), .PRESCALE(3)) d3 (
    .clock(clock), .reset_n(reset_n), .clear(clear), .load(load),
    .load_value(load_value), .enable(enable), .up(up),
    .cnt(cnt3), .tc(tc[3]), .rollover(roll[3]));

  localparam int MODS   [4] = '{4, 10, 10, 10};
  localparam bit SATS   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam int PSS    [4] = '{1, 1, 1, 3};
  localparam int LVMASK [4] = '{3, 15, 15, 15};

  typedef struct {
    int cnt;
    int psc;
    bit roll;
  } mstate_t;

  typedef struct {
    int cnt  [4];
    bit roll [4];
  } exp_t;

  mstate_t ms [4];
  exp_t    sbq [$];

  int n_vec    = 0;
  int n_miscmp = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dut_cnt(input int i);
    case (i)
      0:       return {30'd0, cnt0};
      1:       return {28'd0, cnt1};
      2:       return {28'd0, cnt2};
      default: return {28'd0, cnt3};
    endcase
  endfunction

  function automatic mstate_t model(input mstate_t s, input int i, input bit clr, input bit ld,
                                    input int lv, input bit en, input bit dir);
    mstate_t n;
    int      top;
    int      v;
    n      = s;
    top    = MODS[i] - 1;
    n.roll = 1'b0;
    if (clr) begin
      n.cnt = 0;
      n.psc = 0;
    end else if (ld) begin
      v     = lv & LVMASK[i];
      n.cnt = (v > top) ? top : v;
      n.psc = 0;
    end else if (en) begin
      if (s.psc == PSS[i] - 1) begin
        n.psc = 0;
        if ((dir && s.cnt == top) || (!dir && s.cnt == 0)) begin
          n.roll = 1'b1;
          if (!SATS[i]) n.cnt = dir ? 0 : top;
        end else begin
          n.cnt = dir ? s.cnt + 1 : s.cnt - 1;
        end
      end else begin
        n.psc = s.psc + 1;
      end
    end
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      ms[i].cnt  = 0;
      ms[i].psc  = 0;
      ms[i].roll = 1'b0;
    end
  endtask

  task automatic check_tc(input int i, input int exp_cnt);
    bit exp_tc;
    exp_tc = up ? (exp_cnt == MODS[i] - 1) : (exp_cnt == 0);
    check_value($sformatf("d%0d tc", i), {31'd0, tc[i]}, {31'd0, exp_tc});
  endtask

  // Drive one cycle from the falling edge, predict, then compare after the rising edge.
  task automatic drive(input bit clr, input bit ld, input int lv, input bit en, input bit dir);
    exp_t e;
    clear      = clr;
    load       = ld;
    load_value = 4'(lv);
    enable     = en;
    up         = dir;
    for (int i = 0; i < 4; i++) begin
      ms[i]     = model(ms[i], i, clr, ld, lv, en, dir);
      e.cnt[i]  = ms[i].cnt;
      e.roll[i] = ms[i].roll;
    end
    sbq.push_back(e);
    @(posedge clock);
    #1;
    e = sbq.pop_front();
    for (int i = 0; i < 4; i++) begin
      check_value($sformatf("d%0d cnt", i), dut_cnt(i), e.cnt[i]);
      check_value($sformatf("d%0d rollover", i), {31'd0, roll[i]}, {31'd0, e.roll[i]});
      check_tc(i, e.cnt[i]);
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c33 [5];
    int r33 [5];
    int c35 [5];
    int r35 [5];
    int en_edges;
    bit en;
    c33 = '{1, 2, 3, 0, 1};
    r33 = '{0, 0, 0, 1, 0};
    c35 = '{8, 9, 9, 9, 9};
    r35 = '{0, 0, 1, 1, 1};

    reset_n = 1'b0; clear = 1'b0; load = 1'b0; load_value = '0; enable = 1'b0; up = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      check_value($sformatf("rst d%0d cnt", i), dut_cnt(i), 0);
      check_value($sformatf("rst d%0d rollover", i), {31'd0, roll[i]}, 0);
      check_value($sformatf("rst d%0d tc down", i), {31'd0, tc[i]}, 1);
    end
    up = 1'b1;
    #1;
    check_value("rst d1 tc up", {31'd0, tc[1]}, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // N=2 default count sequence with a single wrap pulse.
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 1, 1);
      check_value($sformatf("seq2 cnt %0d", k), dut_cnt(0), c33[k]);
      check_value($sformatf("seq2 roll %0d", k), {31'd0, roll[0]}, r33[k]);
    end
    check_value("ps3 cnt after 5", dut_cnt(3), 1);

    // Down-wrap from 0 and up-wrap from 9.
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 1, 0);
    check_value("down wrap cnt", dut_cnt(1), 9);
    check_value("down wrap roll", {31'd0, roll[1]}, 1);
    check_value("sat down hold", dut_cnt(2), 0);
    drive(0, 0, 0, 1, 1);
    check_value("up wrap cnt", dut_cnt(1), 0);
    drive(0, 0, 0, 0, 1);
    check_value("roll one cycle", {31'd0, roll[1]}, 0);

    // Saturating count from 7.
    drive(0, 1, 7, 0, 1);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 1, 1);
      check_value($sformatf("sat cnt %0d", k), dut_cnt(2), c35[k]);
      check_value($sformatf("sat roll %0d", k), {31'd0, roll[2]}, r35[k]);
    end

    // Load clamping and clear-over-load priority.
    drive(0, 1, 12, 0, 1);
    check_value("load clamp", dut_cnt(1), 9);
    drive(1, 1, 12, 0, 1);
    check_value("clear beats load", dut_cnt(1), 0);

    // Prescale 3 with two disabled cycles after enabled edge 4; direction flips on a
    // non-step enabled edge must not disturb the prescaler.
    en_edges = 0;
    for (int k = 1; k <= 11; k++) begin
      en = !(k == 5 || k == 6);
      if (en) en_edges++;
      drive(0, 0, 0, en, (k == 2) ? 1'b0 : 1'b1);
      check_value($sformatf("ps3 cnt edge %0d", k), dut_cnt(3), en_edges / 3);
    end

    // Random traffic.
    for (int k = 0; k < 120; k++) begin
      drive($urandom_range(0, 19) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 15),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    // Asynchronous reset in the middle of a clock period.
    drive(0, 1, 5, 0, 1);
    drive(0, 0, 0, 1, 1);
    #2;
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_value($sformatf("async d%0d cnt", i), dut_cnt(i), 0);
      check_value($sformatf("async d%0d rollover", i), {31'd0, roll[i]}, 0);
    end
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) drive(0, 0, 0, 1, 1);
    check_value("post reset d1", dut_cnt(1), 4);
    check_value("post reset ps3", dut_cnt(3), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
MOD_COUNTER -- requirements
Module: mod_counter

Interface
REQ-001 Parameter N, default 8: counter width in bits.
REQ-002 Parameter MODULUS, default 2**N: count range 0..MODULUS-1.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at boundaries, 1 = hold at boundaries.
REQ-004 Parameter PRESCALE, default 1: enabled cycles per count step.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 clear  input  1  synchronous clear to 0.
REQ-008 load  input  1  synchronous load of load_value.
REQ-009 load_value  input  N  value applied on load.
REQ-010 enable  input  1  qualifies prescaler advance and count steps.
REQ-011 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-012 cnt  output  N  registered count value.
REQ-013 tc  output  1  combinational terminal count: up=1 and cnt==MODULUS-1, or up=0 and cnt==0.
REQ-014 rollover  output  1  registered one-cycle pulse per boundary step event.

Function
REQ-015 Elaboration SHALL fail with $fatal unless 2 <= MODULUS <= 2**N and PRESCALE >= 1.
REQ-016 Per-edge priority SHALL be reset_n, then clear, then load, then step.
REQ-017 clear SHALL set cnt=0 and prescaler=0 and SHALL drive rollover=0 in the next cycle.
REQ-018 load SHALL set cnt=min(load_value, MODULUS-1) and prescaler=0; rollover SHALL be 0 in the next cycle.
REQ-019 Internal prescaler width SHALL be max(1, $clog2(PRESCALE)); it advances only when enable=1 and holds when enable=0.
REQ-020 A step SHALL occur on an edge with enable=1 and prescaler==PRESCALE-1; the prescaler SHALL then return to 0.
REQ-021 With PRESCALE=1, every enabled edge SHALL be a step.
REQ-022 Step with up=1 and cnt<MODULUS-1: cnt+1. Step with up=0 and cnt>0: cnt-1.
REQ-023 Step at a boundary (tc=1) with SATURATE=0: cnt SHALL wrap to 0 (up) or MODULUS-1 (down).
REQ-024 Step at a boundary (tc=1) with SATURATE=1: cnt SHALL hold.
REQ-025 rollover SHALL be 1 in the cycle after any step taken with tc=1, in either mode; otherwise 0.
REQ-026 A change of up SHALL NOT reset the prescaler; direction is sampled only on step edges.
REQ-027 All arithmetic SHALL be N bits wide with no overflow beyond MODULUS-1.
REQ-028 The count SHALL NOT change on edges with no step, clear or load.

Reset
REQ-029 reset_n=0 SHALL immediately and asynchronously force cnt=0, prescaler=0 and rollover=0, regardless of clock.
REQ-030 Reset assertion mid-count or mid-prescale SHALL discard all state.
REQ-031 After reset_n deasserts, the first step SHALL occur on the PRESCALE-th enabled edge.
REQ-032 tc SHALL follow cnt and up during reset: 1 when up=0, and 1 when up=1 only if MODULUS-1 is 0, which REQ-015 excludes.

Verification
REQ-033 N=2, defaults, enable=1, up=1, 5 steps from reset: cnt 1,2,3,0,1; rollover pulses exactly once, the cycle after 3->0.
REQ-034 N=4, MODULUS=10, up=0 from cnt=0, one step: cnt=9, rollover=1 for one cycle; up=1 from 9: cnt=0.
REQ-035 N=4, MODULUS=10, SATURATE=1, up=1, load 7, then 5 steps: cnt 8,9,9,9,9; rollover high the cycle after each of the last 3 steps.
REQ-036 N=4, MODULUS=10, load_value=12 with load=1: cnt=9; load and clear asserted together: cnt=0.
REQ-037 PRESCALE=3, enable=1 for 9 edges with enable=0 for 2 cycles inserted after edge 4: cnt increments only after enabled edges 3, 6 and 9.
REQ-038 Async reset: reset_n pulled low mid-clock-period at cnt=5 forces cnt=0 before the next edge; counting resumes from 0 after release.
